// File: rtl/aap_rf_pkg.sv
// rtl/aap_rf_pkg.sv - register file geometry, writeback requester ids and arbiter defaults
package aap_rf_pkg;

    localparam int RF_ADDR_W   = 2;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 4;

    // Writeback requester indices as wired into the arbiter
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    localparam int WB_NUM_REQ      = 3;
    localparam int WB_STARVE_LIMIT = 4;
    localparam int WB_STAT_W       = 16;

    // Next index in a ring of n requesters
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational two-slot picker: starved first, then rotating priority, with same-address masking
module wb_rr_pick
    import aap_rf_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]        valid_i,
    input  logic [NUM_REQ-1:0]        starved_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [IDX_W-1:0]          ptr_i,
    input  logic                      block_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      slot1_vld_o,
    output logic [IDX_W-1:0]          slot1_idx_o,
    output logic                      slot2_vld_o,
    output logic [IDX_W-1:0]          slot2_idx_o
);

    int                pick_idx;
    logic              pick_cand;
    logic [ADDR_W-1:0] slot1_addr;

    // Pass 0 walks starved requesters by index, pass 1 walks the rest from ptr_i upward;
    // the first candidate takes slot 1, the first later one with a different address takes slot 2.
    always_comb begin
        grant_o     = '0;
        slot1_vld_o = 1'b0;
        slot1_idx_o = '0;
        slot2_vld_o = 1'b0;
        slot2_idx_o = '0;
        slot1_addr  = '0;
        pick_idx    = 0;
        pick_cand   = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pass == 0) begin
                    pick_idx = k;
                end else begin
                    pick_idx = int'(ptr_i) + k;
                    if (pick_idx >= NUM_REQ) begin
                        pick_idx = pick_idx - NUM_REQ;
                    end
                end
                pick_cand = valid_i[pick_idx] && !block_i &&
                            ((pass == 0) ? starved_i[pick_idx] : !starved_i[pick_idx]);
                if (pick_cand) begin
                    if (!slot1_vld_o) begin
                        slot1_vld_o       = 1'b1;
                        slot1_idx_o       = IDX_W'(pick_idx);
                        slot1_addr        = addr_i[pick_idx*ADDR_W +: ADDR_W];
                        grant_o[pick_idx] = 1'b1;
                    end else if (!slot2_vld_o &&
                                 (addr_i[pick_idx*ADDR_W +: ADDR_W] != slot1_addr)) begin
                        slot2_vld_o       = 1'b1;
                        slot2_idx_o       = IDX_W'(pick_idx);
                        grant_o[pick_idx] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port register file writeback arbiter; optional stall counters under WB_STATS_EN
module regfile_wb_arbiter
    import aap_rf_pkg::*;
#(
    parameter int NUM_REQ      = WB_NUM_REQ,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic [ADDR_W-1:0]         wr1,
    output logic [ADDR_W-1:0]         wr2,
    output logic [DATA_W-1:0]         wr1_data,
    output logic [DATA_W-1:0]         wr2_data,
    output logic                      wr1_enable,
    output logic                      wr2_enable,
    input  logic [1:0]                stat_sel,
    output logic [15:0]               stat_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0]  age_q [NUM_REQ];
    logic [AGE_W-1:0]  age_d [NUM_REQ];
    logic [NUM_REQ-1:0] starved;

    logic              slot1_vld, slot2_vld;
    logic [IDX_W-1:0]  slot1_idx, slot2_idx;

    logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
    logic [ADDR_W-1:0] wr1_q, wr1_d, wr2_q, wr2_d;
    logic [DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

    // A requester that has waited STARVE_LIMIT cycles jumps ahead of the rotation
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = (age_q[i] == AGE_W'(STARVE_LIMIT));
        end
    end

    wb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i     (req_valid),
        .starved_i   (starved),
        .addr_i      (req_addr),
        .ptr_i       (rr_ptr_q),
        .block_i     (hold),
        .grant_o     (req_ready),
        .slot1_vld_o (slot1_vld),
        .slot1_idx_o (slot1_idx),
        .slot2_vld_o (slot2_vld),
        .slot2_idx_o (slot2_idx)
    );

    // Rotation restarts just past the last granted index (slot 2 if used, else slot 1)
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (slot2_vld) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(slot2_idx), NUM_REQ));
        end else if (slot1_vld) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(slot1_idx), NUM_REQ));
        end
    end

    // Ages count stalled cycles, saturate at the limit, clear on grant or idle, freeze under hold
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = age_q[i];
            if (!hold) begin
                if (!req_valid[i] || req_ready[i]) begin
                    age_d[i] = '0;
                end else if (!starved[i]) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // Load the granted request into each write port; an unused port keeps its address and data
    always_comb begin
        wr1_en_d   = slot1_vld;
        wr1_d      = wr1_q;
        wr1_data_d = wr1_data_q;
        wr2_en_d   = slot2_vld;
        wr2_d      = wr2_q;
        wr2_data_d = wr2_data_q;
        if (slot1_vld) begin
            wr1_d      = req_addr[int'(slot1_idx)*ADDR_W +: ADDR_W];
            wr1_data_d = req_data[int'(slot1_idx)*DATA_W +: DATA_W];
        end
        if (slot2_vld) begin
            wr2_d      = req_addr[int'(slot2_idx)*ADDR_W +: ADDR_W];
            wr2_data_d = req_data[int'(slot2_idx)*DATA_W +: DATA_W];
        end
    end

    // Arbitration state: rotation pointer and per-requester ages
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Registered write ports; reset drops any grant that was about to land
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr1_en_q   <= 1'b0;
            wr1_q      <= '0;
            wr1_data_q <= '0;
            wr2_en_q   <= 1'b0;
            wr2_q      <= '0;
            wr2_data_q <= '0;
        end else begin
            wr1_en_q   <= wr1_en_d;
            wr1_q      <= wr1_d;
            wr1_data_q <= wr1_data_d;
            wr2_en_q   <= wr2_en_d;
            wr2_q      <= wr2_d;
            wr2_data_q <= wr2_data_d;
        end
    end

    assign wr1        = wr1_q;
    assign wr1_data   = wr1_data_q;
    assign wr1_enable = wr1_en_q;
    assign wr2        = wr2_q;
    assign wr2_data   = wr2_data_q;
    assign wr2_enable = wr2_en_q;

`ifdef WB_STATS_EN
    logic [15:0] stat_cnt_q [NUM_REQ];
    logic [15:0] stat_count_q, stat_count_d;

    // Per-requester saturating stall counters (stalls under hold are not counted)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && !hold && (stat_cnt_q[i] != 16'hFFFF)) begin
                    stat_cnt_q[i] <= stat_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Counter readout mux; out-of-range selects read zero
    always_comb begin
        stat_count_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == 2'(i)) begin
                stat_count_d = stat_cnt_q[i];
            end
        end
    end

    // Registered readout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_count_q <= '0;
        end else begin
            stat_count_q <= stat_count_d;
        end
    end

    assign stat_count = stat_count_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table plus corner-case sequences for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [5:0]  req_addr = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        hold = 1'b0;
    logic [1:0]  wr1, wr2;
    logic [15:0] wr1_data, wr2_data;
    logic        wr1_enable, wr2_enable;
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_count;

    int checks = 0;
    int errors = 0;

`ifdef WB_STATS_EN
    localparam int EXP_STAT = 5;
`else
    localparam int EXP_STAT = 0;
`endif

    regfile_wb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hold       (hold),
        .wr1        (wr1),
        .wr2        (wr2),
        .wr1_data   (wr1_data),
        .wr2_data   (wr2_data),
        .wr1_enable (wr1_enable),
        .wr2_enable (wr2_enable),
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] valid;
        logic [1:0] a0, a1, a2;
        logic       hold;
        logic [2:0] ready;
        int         i1, i2;
    } vec_t;

    typedef struct {
        logic        en1;
        logic [1:0]  a1;
        logic [15:0] d1;
        logic        en2;
        logic [1:0]  a2;
        logic [15:0] d2;
    } wr_exp_t;

    localparam int NV = 13;
    vec_t    vecs [NV];
    wr_exp_t sb [$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] data_of(input int i, input int k);
        return 16'((i + 1) * 16'h1000 + k);
    endfunction

    task automatic drive(input logic [2:0] v, input logic [1:0] a0, input logic [1:0] a1,
                         input logic [1:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic h);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        hold      = h;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(3'b000, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0]  ad [3];
        logic [15:0] dd [3];
        wr_exp_t     e;
        logic [2:0]  starve_pat [7];
        int          first_req2;

        vecs[0]  = '{3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, -1, -1};
        vecs[1]  = '{3'b001, 2'd1, 2'd0, 2'd0, 1'b0, 3'b001,  0, -1};
        vecs[2]  = '{3'b001, 2'd2, 2'd0, 2'd0, 1'b0, 3'b001,  0, -1};
        vecs[3]  = '{3'b111, 2'd0, 2'd1, 2'd2, 1'b0, 3'b110,  1,  2};
        vecs[4]  = '{3'b111, 2'd0, 2'd1, 2'd2, 1'b0, 3'b011,  0,  1};
        vecs[5]  = '{3'b111, 2'd0, 2'd1, 2'd2, 1'b0, 3'b101,  2,  0};
        vecs[6]  = '{3'b110, 2'd0, 2'd3, 2'd3, 1'b0, 3'b010,  1, -1};
        vecs[7]  = '{3'b100, 2'd0, 2'd0, 2'd3, 1'b0, 3'b100,  2, -1};
        vecs[8]  = '{3'b111, 2'd0, 2'd1, 2'd2, 1'b1, 3'b000, -1, -1};
        vecs[9]  = '{3'b011, 2'd2, 2'd2, 2'd0, 1'b0, 3'b001,  0, -1};
        vecs[10] = '{3'b010, 2'd0, 2'd0, 2'd0, 1'b0, 3'b010,  1, -1};
        vecs[11] = '{3'b101, 2'd1, 2'd0, 2'd1, 1'b0, 3'b100,  2, -1};
        vecs[12] = '{3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, -1, -1};

        // Reset state
        #2;
        chk("rst_en1", 0, wr1_enable, 1'b0);
        chk("rst_en2", 0, wr2_enable, 1'b0);
        chk("rst_wr1", 0, wr1, 2'd0);
        chk("rst_wr1_data", 0, wr1_data, 16'h0);
        chk("rst_ready", 0, req_ready, 3'b000);
        chk("rst_stat", 0, stat_count, 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // Table vectors with scoreboard of expected write-port contents
        for (int k = 0; k < NV; k++) begin
            @(negedge clock);
            ad[0] = vecs[k].a0;
            ad[1] = vecs[k].a1;
            ad[2] = vecs[k].a2;
            for (int i = 0; i < 3; i++) dd[i] = data_of(i, k);
            drive(vecs[k].valid, ad[0], ad[1], ad[2], dd[0], dd[1], dd[2], vecs[k].hold);
            #1;
            chk("vec_ready", k, req_ready, vecs[k].ready);
            e = '{1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0};
            if (vecs[k].i1 >= 0) begin
                e.en1 = 1'b1;
                e.a1  = ad[vecs[k].i1];
                e.d1  = dd[vecs[k].i1];
            end
            if (vecs[k].i2 >= 0) begin
                e.en2 = 1'b1;
                e.a2  = ad[vecs[k].i2];
                e.d2  = dd[vecs[k].i2];
            end
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk("vec_en1", k, wr1_enable, e.en1);
            chk("vec_en2", k, wr2_enable, e.en2);
            if (e.en1) begin
                chk("vec_wr1", k, wr1, e.a1);
                chk("vec_wr1_data", k, wr1_data, e.d1);
            end
            if (e.en2) begin
                chk("vec_wr2", k, wr2, e.a2);
                chk("vec_wr2_data", k, wr2_data, e.d2);
            end
        end

        // Three-way contention from a fresh pointer
        do_reset();
        drive(3'b111, 2'd0, 2'd1, 2'd2, 16'h0A00, 16'h0A01, 16'h0A02, 1'b0);
        #1 chk("tw_ready1", 0, req_ready, 3'b011);
        tick();
        chk("tw_en1", 0, wr1_enable, 1'b1);
        chk("tw_wr1", 0, wr1, 2'd0);
        chk("tw_en2", 0, wr2_enable, 1'b1);
        chk("tw_wr2", 0, wr2, 2'd1);
        chk("tw_wr2_data", 0, wr2_data, 16'h0A01);
        @(negedge clock);
        #1 chk("tw_ready2", 0, req_ready, 3'b101);
        tick();
        chk("tw_wr1b", 0, wr1, 2'd2);
        chk("tw_wr2b", 0, wr2, 2'd0);

        // Same-register conflict, then held values on an idle cycle
        do_reset();
        drive(3'b011, 2'd3, 2'd3, 2'd0, 16'hAAAA, 16'h5555, 16'h0, 1'b0);
        #1 chk("cf_ready1", 0, req_ready, 3'b001);
        tick();
        chk("cf_wr1", 0, wr1, 2'd3);
        chk("cf_wr1_data", 0, wr1_data, 16'hAAAA);
        chk("cf_en2", 0, wr2_enable, 1'b0);
        @(negedge clock);
        drive(3'b010, 2'd3, 2'd3, 2'd0, 16'hAAAA, 16'h5555, 16'h0, 1'b0);
        #1 chk("cf_ready2", 0, req_ready, 3'b010);
        tick();
        chk("cf_en1b", 0, wr1_enable, 1'b1);
        chk("cf_wr1_datab", 0, wr1_data, 16'h5555);
        @(negedge clock);
        drive(3'b000, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("cf_idle_en1", 0, wr1_enable, 1'b0);
        chk("cf_hold_wr1", 0, wr1, 2'd3);
        chk("cf_hold_data", 0, wr1_data, 16'h5555);

        // Hold for three cycles, grants resume when it drops
        do_reset();
        drive(3'b111, 2'd0, 2'd1, 2'd2, 16'h0B00, 16'h0B01, 16'h0B02, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clock);
            #1 chk("hd_ready", c, req_ready, 3'b000);
            tick();
            chk("hd_en1", c, wr1_enable, 1'b0);
            chk("hd_en2", c, wr2_enable, 1'b0);
        end
        @(negedge clock);
        hold = 1'b0;
        #1 chk("hd_resume", 0, req_ready, 3'b011);
        tick();
        chk("hd_resume_en1", 0, wr1_enable, 1'b1);

        // Reset in the middle of a burst
        do_reset();
        drive(3'b001, 2'd1, 2'd0, 2'd0, 16'h0C00, 16'h0, 16'h0, 1'b0);
        tick();
        chk("mr_en1_pre", 0, wr1_enable, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mr_en1", 0, wr1_enable, 1'b0);
        chk("mr_wr1", 0, wr1, 2'd0);
        chk("mr_wr1_data", 0, wr1_data, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b000, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("mr_quiet", 0, wr1_enable, 1'b0);
        @(negedge clock);
        drive(3'b111, 2'd0, 2'd1, 2'd2, 16'h0D00, 16'h0D01, 16'h0D02, 1'b0);
        #1 chk("mr_ptr0", 0, req_ready, 3'b011);
        tick();

        // All three on one register: rotation, starvation bound and req1 stall count
        do_reset();
        starve_pat[0] = 3'b001; starve_pat[1] = 3'b010; starve_pat[2] = 3'b100;
        starve_pat[3] = 3'b001; starve_pat[4] = 3'b010; starve_pat[5] = 3'b100;
        starve_pat[6] = 3'b001;
        first_req2 = -1;
        stat_sel = 2'd1;
        drive(3'b111, 2'd2, 2'd2, 2'd2, 16'h0E00, 16'h0E01, 16'h0E02, 1'b0);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clock);
            #1 chk("sv_ready", c, req_ready, starve_pat[c]);
            if (req_ready[2] && first_req2 < 0) first_req2 = c + 1;
            tick();
        end
        checks++;
        if (first_req2 < 1 || first_req2 > 5) begin
            errors++;
            $display("FAIL sv_req2_bound: first grant cycle %0d, required 1..5", first_req2);
        end
        @(negedge clock);
        drive(3'b000, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("st_count1", 0, stat_count, 16'(EXP_STAT));
        @(negedge clock);
        stat_sel = 2'd3;
        tick();
        chk("st_sel3", 0, stat_count, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
